// File: rtl/stopwatch_7seg_scan_if.sv
// rtl/stopwatch_7seg_scan_if.sv - digit inputs and display drive bundle for stopwatch_7seg_scan
interface stopwatch_7seg_scan_if;
  logic [3:0] t_10ms;
  logic [3:0] t_100ms;
  logic [3:0] t_1s;
  logic [3:0] t_10s;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output t_10ms, t_100ms, t_1s, t_10s, blank,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  t_10ms, t_100ms, t_1s, t_10s, blank,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/stopwatch_7seg_scan.sv
// rtl/stopwatch_7seg_scan.sv - multiplexed "SS.hh" 7-segment driver with per-frame digit snapshot
// Optional leading-zero blanking of the tens-of-seconds digit: define STOPWATCH_7SEG_LZB_EN.
module stopwatch_7seg_scan #(
  parameter int CLK_DIV        = 8000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                    clk,
  input logic                    rstb,
  stopwatch_7seg_scan_if.slave   disp
);

  localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);
  localparam logic [6:0]  SEG_POL  = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0]  AN_POL   = {4{SEG_ACTIVE_LOW}};

  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [15:0] snapshot;
  logic        frame_tick_q;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic [3:0]  an_q;

  logic        dwell_end;
  logic        frame_end;
  logic [3:0]  cur_digit;
  logic [6:0]  seg_ah;
  logic        lzb_blank;

  assign dwell_end = (cnt == CNT_LAST);
  assign frame_end = dwell_end && (idx == 2'd3);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt          <= '0;
      idx          <= '0;
      snapshot     <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt          <= dwell_end ? '0 : cnt + 16'd1;
      idx          <= dwell_end ? idx + 2'd1 : idx;
      frame_tick_q <= frame_end;
      // Capture all four digits together at the frame boundary so a carry can never tear the display.
      if (frame_end) begin
        snapshot <= {disp.t_10s, disp.t_1s, disp.t_100ms, disp.t_10ms};
      end
    end
  end

  always_comb begin
    cur_digit = snapshot[3:0];
    case (idx)
      2'd0: cur_digit = snapshot[3:0];
      2'd1: cur_digit = snapshot[7:4];
      2'd2: cur_digit = snapshot[11:8];
      2'd3: cur_digit = snapshot[15:12];
      default: cur_digit = snapshot[3:0];
    endcase
  end

  always_comb begin
    seg_ah = 7'h40;
    case (cur_digit)
      4'd0: seg_ah = 7'h3F;
      4'd1: seg_ah = 7'h06;
      4'd2: seg_ah = 7'h5B;
      4'd3: seg_ah = 7'h4F;
      4'd4: seg_ah = 7'h66;
      4'd5: seg_ah = 7'h6D;
      4'd6: seg_ah = 7'h7D;
      4'd7: seg_ah = 7'h07;
      4'd8: seg_ah = 7'h7F;
      4'd9: seg_ah = 7'h6F;
      default: seg_ah = 7'h40;
    endcase
  end

`ifdef STOPWATCH_7SEG_LZB_EN
  assign lzb_blank = (idx == 2'd3) && (snapshot[15:12] == 4'd0);
`else
  assign lzb_blank = 1'b0;
`endif

  // Outputs lag idx by one register stage; polarity is applied by XOR with the active-low mask.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      seg_q <= SEG_POL;
      dp_q  <= SEG_ACTIVE_LOW;
      an_q  <= AN_POL;
    end else if (disp.blank) begin
      seg_q <= SEG_POL;
      dp_q  <= SEG_ACTIVE_LOW;
      an_q  <= AN_POL;
    end else begin
      seg_q <= (lzb_blank ? 7'h00 : seg_ah) ^ SEG_POL;
      dp_q  <= (idx == 2'd2) ^ SEG_ACTIVE_LOW;
      an_q  <= (4'b0001 << idx) ^ AN_POL;
    end
  end

  assign disp.seg        = seg_q;
  assign disp.dp         = dp_q;
  assign disp.an         = an_q;
  assign disp.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_stopwatch_7seg_scan.sv
// tb/tb_stopwatch_7seg_scan.sv - scoreboard bench for stopwatch_7seg_scan
module tb_stopwatch_7seg_scan;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 4 * CLK_DIV;
`ifdef STOPWATCH_7SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stopwatch_7seg_scan_if disp();

  stopwatch_7seg_scan #(.CLK_DIV(CLK_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk  (clk),
    .rstb (rstb),
    .disp (disp)
  );

  function automatic logic [6:0] seg_ah(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic set_digits(input logic [15:0] v);
    disp.t_10s   = v[15:12];
    disp.t_1s    = v[11:8];
    disp.t_100ms = v[7:4];
    disp.t_10ms  = v[3:0];
  endtask

  // Expected display for one whole frame, starting at the first sample after a snapshot load.
  task automatic push_frame(input logic [15:0] v, input int bs, input int bl);
    exp_t       e;
    logic [3:0] one;
    logic [3:0] d;
    int         k;
    one = 4'b0001;
    for (int i = 0; i < FRAME; i++) begin
      k     = i / CLK_DIV;
      d     = v[k*4 +: 4];
      e.an  = ~(one << k);
      e.seg = (LZB && k == 3 && v[15:12] == 4'd0) ? 7'h7F : ~seg_ah(d);
      e.dp  = !(k == 2);
      if (i >= bs && i < bs + bl) begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end
      e.tick = (i == FRAME - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run_frame(input string name, input int bs, input int bl,
                           input int chg, input logic [15:0] nv);
    exp_t e;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s sample %0d: scoreboard empty", name, i);
      end else begin
        e = sb.pop_front();
        if ({disp.an, disp.seg, disp.dp} !== {e.an, e.seg, e.dp}) begin
          errors++;
          $display("FAIL %s sample %0d: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                   name, i, disp.an, disp.seg, disp.dp, e.an, e.seg, e.dp);
        end
        checks++;
        if (disp.frame_tick !== e.tick) begin
          errors++;
          $display("FAIL %s tick sample %0d: frame_tick=%b, expected %b",
                   name, i, disp.frame_tick, e.tick);
        end
      end
      if (i == chg) set_digits(nv);
      if (i + 1 == bs) disp.blank = 1'b1;
      if (i + 1 == bs + bl) disp.blank = 1'b0;
    end
  endtask

  task automatic check_inactive(input string name);
    checks++;
    if (disp.an !== 4'hF) begin
      errors++;
      $display("FAIL %s an: got %b, expected 1111", name, disp.an);
    end
    checks++;
    if (disp.seg !== 7'h7F) begin
      errors++;
      $display("FAIL %s seg: got %h, expected 7f", name, disp.seg);
    end
    checks++;
    if (disp.dp !== 1'b1) begin
      errors++;
      $display("FAIL %s dp: got %b, expected 1", name, disp.dp);
    end
    checks++;
    if (disp.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_tick: got %b, expected 0", name, disp.frame_tick);
    end
  endtask

  task automatic test_reset();
    disp.blank = 1'b0;
    set_digits(16'h1234);
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    check_inactive("reset_hold");
    rstb = 1'b1;
  endtask

  task automatic test_scan();
    push_frame(16'h0000, 0, 0);
    run_frame("first_frame", 0, 0, -1, 16'h0000);
    push_frame(16'h1234, 0, 0);
    run_frame("scan_1234", 0, 0, 4, 16'h0999);
  endtask

  task automatic test_tear();
    push_frame(16'h0999, 0, 0);
    run_frame("tear_0999", 0, 0, 5, 16'h1000);
    push_frame(16'h1000, 0, 0);
    run_frame("tear_1000", 0, 0, 2, 16'h07C5);
  endtask

  task automatic test_invalid_bcd();
    push_frame(16'h07C5, 0, 0);
    run_frame("invalid_bcd", 0, 0, 2, 16'h0725);
  endtask

  task automatic test_blank_lzb();
    push_frame(16'h0725, 6, 6);
    run_frame("blank_mid_lzb", 6, 6, -1, 16'h0000);
  endtask

  task automatic test_blank_snapshot();
    push_frame(16'h0725, 14, 2);
    run_frame("blank_on_load", 14, 2, 2, 16'h5986);
    push_frame(16'h5986, 0, 0);
    run_frame("after_blank_load", 0, 0, -1, 16'h0000);
  endtask

  task automatic test_back_to_back_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (disp.an === 4'hF) begin
      errors++;
      $display("FAIL pre_reset_active: an=%b, expected one digit enabled", disp.an);
    end
    #2 rstb = 1'b0;
    #1 check_inactive("async_reset");
    @(negedge clk);
    set_digits(16'h4321);
    rstb = 1'b1;
    push_frame(16'h0000, 0, 0);
    run_frame("restart_first", 0, 0, -1, 16'h0000);
    push_frame(16'h4321, 0, 0);
    run_frame("restart_4321", 0, 0, -1, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear();
    test_invalid_bcd();
    test_blank_lzb();
    test_blank_snapshot();
    test_back_to_back_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
